alu_rs: RTL

- Reservation station feeding the integer ALU. It is the producer end of the ALU's op/in1/in2 interface.
- Accepts dispatched ALU micro-ops whose operands are either values or pending RRF tags.
- Captures pending operands from the result broadcast bus (CDB).
- Issues the oldest fully-ready entry to the ALU through a registered, stallable issue stage.

---
 rtl/alu_rs_pkg.sv | 40 ++++
 rtl/alu_rs_oldest_sel.sv | 27 ++
 rtl/alu_rs.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_pkg.sv
// Shared widths and small helpers for the ALU reservation station.
// ALU opcode encodings live in the ALU's own op header, not here.
package alu_rs_pkg;

  localparam int DEF_ENTRY_NUM    = 4;
  localparam int DEF_XPR_LEN      = 32;
  localparam int DEF_ALU_OP_WIDTH = 4;
  localparam int DEF_TAG_WIDTH    = 6;
  localparam int MAX_ENTRY_NUM    = 8;

  // Entry field layout at default widths: busy | op | src1 | vld1 | src2 | vld2 | rrftag
  typedef struct packed {
    logic                        busy;
    logic [DEF_ALU_OP_WIDTH-1:0] op;
    logic [DEF_XPR_LEN-1:0]      src1;
    logic                        vld1;
    logic [DEF_XPR_LEN-1:0]      src2;
    logic                        vld2;
    logic [DEF_TAG_WIDTH-1:0]    rrftag;
  } rs_entry_t;

  function automatic logic [3:0] popcount8(input logic [MAX_ENTRY_NUM-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < MAX_ENTRY_NUM; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic [2:0] onehot_idx8(input logic [MAX_ENTRY_NUM-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < MAX_ENTRY_NUM; i++) begin
      idx = idx | (v[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_rs_oldest_sel.sv
// Age-matrix oldest-ready picker: grants the ready entry that no other
// ready entry is older than. Purely combinational.
module alu_rs_oldest_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] older,
  output logic [N-1:0]        grant,
  output logic                found
);

  logic [N-1:0] blocked_s;

  // An entry is blocked when any other ready entry was dispatched before it
  always_comb begin
    blocked_s = '0;
    grant     = '0;
    found     = |ready;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        blocked_s[i] = blocked_s[i] | (ready[j] & older[j][i] & (j != i));
      end
      grant[i] = ready[i] & ~blocked_s[i];
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: dispatch, CDB wakeup/bypass,
// oldest-ready select and a registered, stallable issue stage.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int ENTRY_NUM    = DEF_ENTRY_NUM,
  parameter int XPR_LEN      = DEF_XPR_LEN,
  parameter int ALU_OP_WIDTH = DEF_ALU_OP_WIDTH,
  parameter int TAG_WIDTH    = DEF_TAG_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         kill,
  input  logic                         dp_valid,
  output logic                         dp_ready,
  input  logic [ALU_OP_WIDTH-1:0]      dp_op,
  input  logic [XPR_LEN-1:0]           dp_src1,
  input  logic                         dp_vld1,
  input  logic [XPR_LEN-1:0]           dp_src2,
  input  logic                         dp_vld2,
  input  logic [TAG_WIDTH-1:0]         dp_rrftag,
  input  logic                         cdb_valid,
  input  logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic [XPR_LEN-1:0]           cdb_data,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [ALU_OP_WIDTH-1:0]      iss_op,
  output logic [XPR_LEN-1:0]           iss_in1,
  output logic [XPR_LEN-1:0]           iss_in2,
  output logic [TAG_WIDTH-1:0]         iss_rrftag,
  output logic [$clog2(ENTRY_NUM):0]   count
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = $clog2(ENTRY_NUM) + 1;

  typedef struct packed {
    logic                    busy;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [XPR_LEN-1:0]      src1;
    logic                    vld1;
    logic [XPR_LEN-1:0]      src2;
    logic                    vld2;
    logic [TAG_WIDTH-1:0]    rrftag;
  } entry_t;

  entry_t                              ent_r [ENTRY_NUM];
  logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] older_r;
  logic                                iss_valid_r;
  logic [ALU_OP_WIDTH-1:0]             iss_op_r;
  logic [XPR_LEN-1:0]                  iss_in1_r;
  logic [XPR_LEN-1:0]                  iss_in2_r;
  logic [TAG_WIDTH-1:0]                iss_rrftag_r;
  logic [CNT_W-1:0]                    count_r;

  logic [ENTRY_NUM-1:0]     busy_s;
  logic [ENTRY_NUM-1:0]     ready_s;
  logic [ENTRY_NUM-1:0]     wake1_s;
  logic [ENTRY_NUM-1:0]     wake2_s;
  logic [ENTRY_NUM-1:0]     grant_s;
  logic [ENTRY_NUM-1:0]     busy_nx_s;
  logic [MAX_ENTRY_NUM-1:0] busy8_nx_s;
  logic [MAX_ENTRY_NUM-1:0] grant8_s;
  logic                     found_s;
  logic                     dp_ready_s;
  logic                     dp_fire_s;
  logic                     advance_s;
  logic                     issue_s;
  logic [IDX_W-1:0]         free_idx_s;
  logic [IDX_W-1:0]         win_idx_s;
  logic                     dp_v1_s;
  logic                     dp_v2_s;
  logic [XPR_LEN-1:0]       dp_s1_s;
  logic [XPR_LEN-1:0]       dp_s2_s;

  // Per-entry status, wakeup match and lowest-index free slot (descending scan)
  always_comb begin
    busy_s     = '0;
    ready_s    = '0;
    wake1_s    = '0;
    wake2_s    = '0;
    free_idx_s = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      busy_s[i]  = ent_r[i].busy;
      ready_s[i] = ent_r[i].busy & ent_r[i].vld1 & ent_r[i].vld2;
      wake1_s[i] = ent_r[i].busy & ~ent_r[i].vld1 & cdb_valid &
                   (ent_r[i].src1[TAG_WIDTH-1:0] == cdb_tag);
      wake2_s[i] = ent_r[i].busy & ~ent_r[i].vld2 & cdb_valid &
                   (ent_r[i].src2[TAG_WIDTH-1:0] == cdb_tag);
      free_idx_s = ent_r[i].busy ? free_idx_s : IDX_W'(i);
    end
  end

  alu_rs_oldest_sel #(.N(ENTRY_NUM)) u_sel (
    .ready (ready_s),
    .older (older_r),
    .grant (grant_s),
    .found (found_s)
  );

  // Dispatch-side CDB bypass so a same-cycle broadcast is not missed
  always_comb begin
    dp_v1_s = dp_vld1 | (cdb_valid & (dp_src1[TAG_WIDTH-1:0] == cdb_tag));
    dp_v2_s = dp_vld2 | (cdb_valid & (dp_src2[TAG_WIDTH-1:0] == cdb_tag));
    dp_s1_s = (!dp_vld1 && dp_v1_s) ? cdb_data : dp_src1;
    dp_s2_s = (!dp_vld2 && dp_v2_s) ? cdb_data : dp_src2;
  end

  // Handshakes and next busy vector (used for the registered count)
  always_comb begin
    dp_ready_s = ~&busy_s;
    dp_fire_s  = dp_valid & dp_ready_s & ~kill;
    advance_s  = ~iss_valid_r | iss_ready;
    issue_s    = advance_s & found_s;
    busy_nx_s  = '0;
    busy8_nx_s = '0;
    grant8_s   = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      busy_nx_s[i] = ~kill & ((busy_s[i] & ~(issue_s & grant_s[i])) |
                              (dp_fire_s & (free_idx_s == IDX_W'(i))));
      busy8_nx_s[i] = busy_nx_s[i];
      grant8_s[i]   = grant_s[i];
    end
    win_idx_s = IDX_W'(onehot_idx8(grant8_s));
  end

  // Entry array, age matrix, issue register and count
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        ent_r[i] <= '0;
      end
      older_r      <= '0;
      iss_valid_r  <= 1'b0;
      iss_op_r     <= '0;
      iss_in1_r    <= '0;
      iss_in2_r    <= '0;
      iss_rrftag_r <= '0;
      count_r      <= '0;
    end else begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        ent_r[i].busy <= busy_nx_s[i];
        if (dp_fire_s && (free_idx_s == IDX_W'(i))) begin
          ent_r[i].op     <= dp_op;
          ent_r[i].src1   <= dp_s1_s;
          ent_r[i].vld1   <= dp_v1_s;
          ent_r[i].src2   <= dp_s2_s;
          ent_r[i].vld2   <= dp_v2_s;
          ent_r[i].rrftag <= dp_rrftag;
        end else begin
          if (wake1_s[i]) begin
            ent_r[i].src1 <= cdb_data;
            ent_r[i].vld1 <= 1'b1;
          end
          if (wake2_s[i]) begin
            ent_r[i].src2 <= cdb_data;
            ent_r[i].vld2 <= 1'b1;
          end
        end
      end
      if (dp_fire_s) begin
        for (int j = 0; j < ENTRY_NUM; j++) begin
          if (busy_s[j]) begin
            older_r[j][free_idx_s] <= 1'b1;
            older_r[free_idx_s][j] <= 1'b0;
          end
        end
      end
      if (kill) begin
        iss_valid_r <= 1'b0;
      end else if (advance_s) begin
        if (found_s) begin
          iss_valid_r  <= 1'b1;
          iss_op_r     <= ent_r[win_idx_s].op;
          iss_in1_r    <= ent_r[win_idx_s].src1;
          iss_in2_r    <= ent_r[win_idx_s].src2;
          iss_rrftag_r <= ent_r[win_idx_s].rrftag;
        end else begin
          iss_valid_r <= 1'b0;
        end
      end
      count_r <= CNT_W'(popcount8(busy8_nx_s));
    end
  end

  assign dp_ready   = dp_ready_s;
  assign iss_valid  = iss_valid_r;
  assign iss_op     = iss_op_r;
  assign iss_in1    = iss_in1_r;
  assign iss_in2    = iss_in2_r;
  assign iss_rrftag = iss_rrftag_r;
  assign count      = count_r;

endmodule
